// File: rtl/sram_axi_bridge.sv
// sram_axi_bridge: multiplexes NCH SRAM-like client channels onto one AXI
// master port. Reads from several channels may be in flight at once and
// return out of order by ID (ID = channel index); only one write is in
// flight at a time, and reads are held off while it is outstanding.
module sram_axi_bridge #(
    parameter int NCH  = 2,
    parameter int ID_W = 4
) (
    input  logic                clk,
    input  logic                reset,

    input  logic [NCH-1:0]      sram_req,
    input  logic [NCH-1:0]      sram_wr,
    input  logic [4*NCH-1:0]    sram_wstrb,
    input  logic [32*NCH-1:0]   sram_addr,
    input  logic [32*NCH-1:0]   sram_wdata,
    output logic [NCH-1:0]      sram_addr_ok,
    output logic [NCH-1:0]      sram_data_ok,
    output logic [32*NCH-1:0]   sram_rdata,

    output logic                ar_valid,
    input  logic                ar_ready,
    output logic [ID_W-1:0]     ar_id,
    output logic [31:0]         ar_addr,

    input  logic                r_valid,
    output logic                r_ready,
    input  logic [ID_W-1:0]     r_id,
    input  logic [31:0]         r_data,

    output logic                aw_valid,
    input  logic                aw_ready,
    output logic [31:0]         aw_addr,

    output logic                w_valid,
    input  logic                w_ready,
    output logic [31:0]         w_data,
    output logic [3:0]          w_strb,
    input  logic                b_valid,
    output logic                b_ready
);

    logic [NCH-1:0]  busy;        // channel has a transaction in flight
    logic            wr_pend;     // the single write is awaiting its B
    logic [ID_W-1:0] wr_owner;    // channel that issued that write

    logic [NCH-1:0]  grant;       // fixed-priority winner among requesters
    logic            lower_req;
    logic            rd_free;
    logic            wr_free;

    logic            acc_rd;
    logic            acc_wr;
    logic [ID_W-1:0] sel_id;
    logic [31:0]     sel_addr;
    logic [31:0]     sel_wdata;
    logic [3:0]      sel_wstrb;

    // The slave side is always able to sink responses.
    assign r_ready = 1'b1;
    assign b_ready = 1'b1;

    // Reads must not overtake a pending write; a new write needs both
    // write channels idle and the previous B received.
    assign rd_free = !ar_valid && !wr_pend;
    assign wr_free = !aw_valid && !w_valid && !wr_pend;

    // Fixed-priority grant: lowest-index requester wins, even if it is busy.
    always_comb begin
        // NOTE: every variable driven here gets a default first, otherwise
        // paths that skip an assignment would infer a latch.
        grant     = '0;
        lower_req = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (sram_req[i] && !lower_req)
                grant[i] = 1'b1;
            lower_req = lower_req | sram_req[i];
        end
    end

    // Accept the granted channel when it is idle and its path is free.
    always_comb begin
        sram_addr_ok = '0;
        for (int i = 0; i < NCH; i++)
            sram_addr_ok[i] = !reset && grant[i] && !busy[i] &&
                              (sram_wr[i] ? wr_free : rd_free);
    end

    // Pick out the fields of the accepted request (addr_ok is one-hot or zero).
    always_comb begin
        acc_rd    = 1'b0;
        acc_wr    = 1'b0;
        sel_id    = '0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_wstrb = '0;
        for (int i = 0; i < NCH; i++) begin
            if (sram_addr_ok[i]) begin
                acc_rd    = !sram_wr[i];
                acc_wr    = sram_wr[i];
                sel_id    = ID_W'(i);
                sel_addr  = sram_addr[32*i +: 32];
                sel_wdata = sram_wdata[32*i +: 32];
                sel_wstrb = sram_wstrb[4*i +: 4];
            end
        end
    end

    // Route R by ID and B by owner back to the channels, same cycle.
    // An R whose ID matches the channel holding the write is stale and dropped.
    always_comb begin
        sram_data_ok = '0;
        sram_rdata   = '0;
        for (int i = 0; i < NCH; i++) begin
            sram_rdata[32*i +: 32] = r_data;
            sram_data_ok[i] = !reset && (
                (r_valid && (r_id == ID_W'(i)) && busy[i] &&
                 !(wr_pend && (wr_owner == ID_W'(i)))) ||
                (b_valid && wr_pend && (wr_owner == ID_W'(i))));
        end
    end

    // Per-channel busy flags: set on acceptance, cleared on response.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments only, so all
        // registers sample the pre-edge values consistently.
        if (reset)
            busy <= '0;
        else
            busy <= (busy & ~sram_data_ok) | sram_addr_ok;
    end

    // AR channel: launch an accepted read, hold it until the handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ar_valid <= 1'b0;
            ar_id    <= '0;
            ar_addr  <= '0;
        end else if (acc_rd) begin
            ar_valid <= 1'b1;
            ar_id    <= sel_id;
            ar_addr  <= sel_addr;
        end else if (ar_valid && ar_ready) begin
            ar_valid <= 1'b0;
        end
    end

    // AW/W channels: raised together, each dropped on its own handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            aw_valid <= 1'b0;
            w_valid  <= 1'b0;
            aw_addr  <= '0;
            w_data   <= '0;
            w_strb   <= '0;
        end else if (acc_wr) begin
            aw_valid <= 1'b1;
            w_valid  <= 1'b1;
            aw_addr  <= sel_addr;
            w_data   <= sel_wdata;
            w_strb   <= sel_wstrb;
        end else begin
            if (aw_valid && aw_ready)
                aw_valid <= 1'b0;
            if (w_valid && w_ready)
                w_valid <= 1'b0;
        end
    end

    // Write bookkeeping: the write stays pending from acceptance until B.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_pend  <= 1'b0;
            wr_owner <= '0;
        end else if (acc_wr) begin
            wr_pend  <= 1'b1;
            wr_owner <= sel_id;
        end else if (b_valid && wr_pend) begin
            wr_pend  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed bench for sram_axi_bridge: single read latency, priority,
// out-of-order return, write-then-read blocking, concurrent R/B, stale
// responses and reset mid-transaction.
module tb_sram_axi_bridge;

    localparam int NCH  = 2;
    localparam int ID_W = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [NCH-1:0]    sram_req;
    logic [NCH-1:0]    sram_wr;
    logic [4*NCH-1:0]  sram_wstrb;
    logic [32*NCH-1:0] sram_addr;
    logic [32*NCH-1:0] sram_wdata;
    logic [NCH-1:0]    sram_addr_ok;
    logic [NCH-1:0]    sram_data_ok;
    logic [32*NCH-1:0] sram_rdata;
    logic              ar_valid;
    logic              ar_ready;
    logic [ID_W-1:0]   ar_id;
    logic [31:0]       ar_addr;
    logic              r_valid;
    logic              r_ready;
    logic [ID_W-1:0]   r_id;
    logic [31:0]       r_data;
    logic              aw_valid;
    logic              aw_ready;
    logic [31:0]       aw_addr;
    logic              w_valid;
    logic              w_ready;
    logic [31:0]       w_data;
    logic [3:0]        w_strb;
    logic              b_valid;
    logic              b_ready;

    int vectors     = 0;
    int miscompares = 0;

    sram_axi_bridge #(.NCH(NCH), .ID_W(ID_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .sram_req     (sram_req),
        .sram_wr      (sram_wr),
        .sram_wstrb   (sram_wstrb),
        .sram_addr    (sram_addr),
        .sram_wdata   (sram_wdata),
        .sram_addr_ok (sram_addr_ok),
        .sram_data_ok (sram_data_ok),
        .sram_rdata   (sram_rdata),
        .ar_valid     (ar_valid),
        .ar_ready     (ar_ready),
        .ar_id        (ar_id),
        .ar_addr      (ar_addr),
        .r_valid      (r_valid),
        .r_ready      (r_ready),
        .r_id         (r_id),
        .r_data       (r_data),
        .aw_valid     (aw_valid),
        .aw_ready     (aw_ready),
        .aw_addr      (aw_addr),
        .w_valid      (w_valid),
        .w_ready      (w_ready),
        .w_data       (w_data),
        .w_strb       (w_strb),
        .b_valid      (b_valid),
        .b_ready      (b_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs change here.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        sram_req   = '0;
        sram_wr    = '0;
        sram_wstrb = '0;
        sram_addr  = '0;
        sram_wdata = '0;
        ar_ready   = 1'b0;
        r_valid    = 1'b0;
        r_id       = '0;
        r_data     = '0;
        aw_ready   = 1'b0;
        w_ready    = 1'b0;
        b_valid    = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        idle();

        // ---- reset state: requests and responses are suppressed ----
        tick();
        sram_req = 2'b11;
        r_valid  = 1'b1;
        b_valid  = 1'b1;
        #1;
        chk("rst_addr_ok", 32'(sram_addr_ok), 32'h0);
        chk("rst_data_ok", 32'(sram_data_ok), 32'h0);
        chk("rst_ar_valid", 32'(ar_valid), 32'h0);
        chk("rst_aw_valid", 32'(aw_valid), 32'h0);
        chk("rst_w_valid", 32'(w_valid), 32'h0);
        chk("rst_r_ready", 32'(r_ready), 32'h1);
        chk("rst_b_ready", 32'(b_ready), 32'h1);
        tick();
        idle();
        reset = 1'b0;
        tick();

        // ---- single read on ch1, minimum latency ----
        sram_req = 2'b10;
        sram_addr[63:32] = 32'h1c00_0000;
        #1;
        chk("rd1_c0_addr_ok", 32'(sram_addr_ok), 32'h2);
        tick();
        idle();
        ar_ready = 1'b1;
        #1;
        chk("rd1_c1_ar_valid", 32'(ar_valid), 32'h1);
        chk("rd1_c1_ar_id", 32'(ar_id), 32'h1);
        chk("rd1_c1_ar_addr", ar_addr, 32'h1c00_0000);
        tick();
        ar_ready = 1'b0;
        r_valid  = 1'b1;
        r_id     = 4'd1;
        r_data   = 32'hDEAD_BEEF;
        #1;
        chk("rd1_c2_ar_valid", 32'(ar_valid), 32'h0);
        chk("rd1_c2_data_ok", 32'(sram_data_ok), 32'h2);
        chk("rd1_c2_rdata1", sram_rdata[63:32], 32'hDEAD_BEEF);
        tick();
        idle();
        #1;
        chk("rd1_c3_data_ok", 32'(sram_data_ok), 32'h0);

        // ---- priority: ch0 and ch1 read together ----
        sram_req = 2'b11;
        sram_addr[31:0]  = 32'h0000_0100;
        sram_addr[63:32] = 32'h0000_0200;
        #1;
        chk("pri_c0_addr_ok", 32'(sram_addr_ok), 32'h1);
        tick();
        sram_req = 2'b10;
        ar_ready = 1'b1;
        #1;
        chk("pri_c1_ar_id", 32'(ar_id), 32'h0);
        chk("pri_c1_ar_addr", ar_addr, 32'h0000_0100);
        chk("pri_c1_addr_ok", 32'(sram_addr_ok), 32'h0);
        tick();
        ar_ready = 1'b0;
        #1;
        chk("pri_c2_addr_ok", 32'(sram_addr_ok), 32'h2);
        tick();
        sram_req = 2'b00;
        ar_ready = 1'b1;
        #1;
        chk("pri_c3_ar_valid", 32'(ar_valid), 32'h1);
        chk("pri_c3_ar_id", 32'(ar_id), 32'h1);
        chk("pri_c3_ar_addr", ar_addr, 32'h0000_0200);
        tick();

        // ---- out-of-order return: id 1 then id 0 ----
        ar_ready = 1'b0;
        sram_req = 2'b10;
        r_valid  = 1'b1;
        r_id     = 4'd1;
        r_data   = 32'h1111_1111;
        #1;
        chk("ooo_r1_data_ok", 32'(sram_data_ok), 32'h2);
        chk("ooo_r1_rdata1", sram_rdata[63:32], 32'h1111_1111);
        chk("ooo_busy_addr_ok", 32'(sram_addr_ok), 32'h0);
        tick();
        sram_req = 2'b00;
        r_id     = 4'd0;
        r_data   = 32'h2222_2222;
        #1;
        chk("ooo_r0_data_ok", 32'(sram_data_ok), 32'h1);
        chk("ooo_r0_rdata0", sram_rdata[31:0], 32'h2222_2222);
        tick();
        r_id = 4'd1;
        #1;
        chk("stale_r_idle_ch", 32'(sram_data_ok), 32'h0);
        tick();
        r_id = 4'd5;
        #1;
        chk("r_id_out_of_range", 32'(sram_data_ok), 32'h0);
        tick();
        idle();

        // ---- write on ch0, aw_ready late, ch1 read blocked until B ----
        sram_req   = 2'b01;
        sram_wr    = 2'b01;
        sram_wstrb = 8'h03;
        sram_addr[31:0]  = 32'h0000_0300;
        sram_wdata[31:0] = 32'hCAFE_F00D;
        #1;
        chk("wr_c0_addr_ok", 32'(sram_addr_ok), 32'h1);
        tick();
        idle();
        w_ready  = 1'b1;
        sram_req = 2'b10;
        sram_addr[63:32] = 32'h0000_0400;
        #1;
        chk("wr_c1_aw_valid", 32'(aw_valid), 32'h1);
        chk("wr_c1_w_valid", 32'(w_valid), 32'h1);
        chk("wr_c1_aw_addr", aw_addr, 32'h0000_0300);
        chk("wr_c1_w_data", w_data, 32'hCAFE_F00D);
        chk("wr_c1_w_strb", 32'(w_strb), 32'h3);
        chk("wr_c1_rd_blocked", 32'(sram_addr_ok), 32'h0);
        tick();
        w_ready = 1'b0;
        #1;
        chk("wr_c2_w_valid", 32'(w_valid), 32'h0);
        chk("wr_c2_aw_valid", 32'(aw_valid), 32'h1);
        tick();
        #1;
        chk("wr_c3_aw_valid", 32'(aw_valid), 32'h1);
        tick();
        aw_ready = 1'b1;
        #1;
        chk("wr_c4_aw_valid", 32'(aw_valid), 32'h1);
        tick();
        aw_ready = 1'b0;
        #1;
        chk("wr_c5_aw_valid", 32'(aw_valid), 32'h0);
        chk("wr_c5_rd_blocked", 32'(sram_addr_ok), 32'h0);
        tick();
        b_valid = 1'b1;
        #1;
        chk("wr_b_data_ok", 32'(sram_data_ok), 32'h1);
        chk("wr_b_rd_blocked", 32'(sram_addr_ok), 32'h0);
        tick();
        b_valid = 1'b0;
        #1;
        chk("wr_after_b_addr_ok", 32'(sram_addr_ok), 32'h2);
        tick();
        sram_req = 2'b00;
        ar_ready = 1'b1;
        #1;
        chk("wr_after_b_ar_id", 32'(ar_id), 32'h1);
        chk("wr_after_b_ar_addr", ar_addr, 32'h0000_0400);
        tick();
        ar_ready = 1'b0;

        // ---- write on ch0 while ch1 read outstanding; R and B together ----
        sram_req   = 2'b01;
        sram_wr    = 2'b01;
        sram_wstrb = 8'h0F;
        sram_addr[31:0]  = 32'h0000_0500;
        sram_wdata[31:0] = 32'h0BAD_F00D;
        #1;
        chk("rb_wr_addr_ok", 32'(sram_addr_ok), 32'h1);
        tick();
        idle();
        aw_ready = 1'b1;
        w_ready  = 1'b1;
        #1;
        chk("rb_w_strb", 32'(w_strb), 32'hF);
        tick();
        idle();
        r_valid = 1'b1;
        r_id    = 4'd1;
        r_data  = 32'h3333_3333;
        b_valid = 1'b1;
        #1;
        chk("rb_both_data_ok", 32'(sram_data_ok), 32'h3);
        chk("rb_rdata1", sram_rdata[63:32], 32'h3333_3333);
        tick();
        r_valid = 1'b0;
        #1;
        chk("stale_b_data_ok", 32'(sram_data_ok), 32'h0);
        tick();
        idle();

        // ---- reset with a read outstanding ----
        sram_req = 2'b10;
        sram_addr[63:32] = 32'h0000_0600;
        #1;
        chk("rr_addr_ok", 32'(sram_addr_ok), 32'h2);
        tick();
        idle();
        #1;
        chk("rr_ar_valid", 32'(ar_valid), 32'h1);
        reset = 1'b1;
        #1;
        chk("rr_async_ar_valid", 32'(ar_valid), 32'h0);
        tick();
        reset   = 1'b0;
        r_valid = 1'b1;
        r_id    = 4'd1;
        r_data  = 32'h4444_4444;
        #1;
        chk("rr_stale_r", 32'(sram_data_ok), 32'h0);
        tick();
        idle();
        sram_req = 2'b10;
        sram_addr[63:32] = 32'h0000_0700;
        #1;
        chk("rr_new_addr_ok", 32'(sram_addr_ok), 32'h2);
        tick();
        idle();
        ar_ready = 1'b1;
        #1;
        chk("rr_new_ar_addr", ar_addr, 32'h0000_0700);
        tick();
        ar_ready = 1'b0;
        r_valid  = 1'b1;
        r_id     = 4'd1;
        r_data   = 32'h5555_5555;
        #1;
        chk("rr_new_data_ok", 32'(sram_data_ok), 32'h2);
        tick();
        idle();

        // ---- reset with a write outstanding ----
        sram_req   = 2'b01;
        sram_wr    = 2'b01;
        sram_wstrb = 8'h01;
        #1;
        chk("rw_addr_ok", 32'(sram_addr_ok), 32'h1);
        tick();
        idle();
        #1;
        chk("rw_aw_valid", 32'(aw_valid), 32'h1);
        reset = 1'b1;
        #1;
        chk("rw_async_aw_valid", 32'(aw_valid), 32'h0);
        chk("rw_async_w_valid", 32'(w_valid), 32'h0);
        tick();
        reset   = 1'b0;
        b_valid = 1'b1;
        #1;
        chk("rw_stale_b", 32'(sram_data_ok), 32'h0);
        tick();
        idle();
        sram_req = 2'b10;
        #1;
        chk("rw_rd_unblocked", 32'(sram_addr_ok), 32'h2);
        tick();
        idle();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sram_axi_bridge.md
SRAM_AXI_BRIDGE -- requirements
Module: sram_axi_bridge

Interface
REQ-001 The block SHALL have parameter NCH, default 2, giving the number of SRAM-like client channels (1..8).
REQ-002 The block SHALL have parameter ID_W, default 4, giving the AXI ID width, with 2**ID_W >= NCH.
REQ-003 Port clk  input  1  single clock; all state SHALL be updated on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port sram_req  input  NCH  per-channel request.
REQ-006 Port sram_wr  input  NCH  per-channel write (1) / read (0).
REQ-007 Port sram_wstrb  input  4*NCH  per-channel byte strobes, packed with channel i at [4i+3:4i].
REQ-008 Port sram_addr  input  32*NCH  per-channel word address, packed.
REQ-009 Port sram_wdata  input  32*NCH  per-channel write data, packed.
REQ-010 Port sram_addr_ok  output  NCH  per-channel request accepted this cycle.
REQ-011 Port sram_data_ok  output  NCH  per-channel response this cycle.
REQ-012 Port sram_rdata  output  32*NCH  per-channel read data, valid with data_ok.
REQ-013 Read-address port group, in order: ar_valid output 1; ar_ready input 1; ar_id output ID_W; ar_addr output 32.
REQ-014 Read-data port group, in order: r_valid input 1; r_ready output 1; r_id input ID_W; r_data input 32.
REQ-015 Write-address port group, in order: aw_valid output 1; aw_ready input 1; aw_addr output 32.
REQ-016 Write-data and write-response port group, in order: w_valid output 1; w_ready input 1; w_data output 32; w_strb output 4; b_valid input 1; b_ready output 1.

Function
REQ-017 Each channel SHALL have at most one outstanding transaction; busy[i] SHALL be set on acceptance (req&addr_ok) and cleared on data_ok[i].
REQ-018 Arbitration SHALL be fixed priority, with the lowest index highest; addr_ok SHALL be one-hot or zero.
REQ-019 addr_ok[i] SHALL be combinational and asserted iff: req[i]; no lower-index req; !busy[i]; and the path is free (read: ar_valid=0 and no write outstanding; write: aw_valid=0, w_valid=0 and no write outstanding).
REQ-020 An accepted read SHALL register ar_addr=addr, ar_id=i, and ar_valid=1 on the next edge; ar_valid SHALL clear on the ar_valid&ar_ready edge, with fields held stable until then.
REQ-021 An accepted write SHALL assert aw_valid and w_valid together on the next edge (aw_addr, w_data, w_strb registered, wr_owner=i); each valid SHALL drop independently on its own handshake; wr_pend SHALL be held until b.
REQ-022 r_ready and b_ready SHALL be 1 whenever out of reset.
REQ-023 On r_valid with r_id=i<NCH and busy[i]: data_ok[i]=1 and rdata[i]=r_data in the same cycle (combinational); r_id>=NCH or a non-busy channel SHALL be ignored.
REQ-024 On b_valid with wr_pend: data_ok[wr_owner]=1; wr_pend SHALL clear on that edge; b_valid without wr_pend SHALL be ignored.
REQ-025 When R and B complete for different channels in the same cycle, both data_ok bits SHALL assert.
REQ-026 Reads from up to NCH channels MAY be outstanding at once with out-of-order return by ID; any read SHALL be blocked while a write is outstanding (RAW safety).
REQ-027 Minimum latency SHALL be: accept at cycle 0, ar_valid at cycle 1, data_ok at cycle 2 if ar_ready=1 and the slave replies in the next cycle.

Reset
REQ-028 Reset SHALL asynchronously clear ar_valid, aw_valid, w_valid, busy[], and wr_pend; r_ready and b_ready SHALL reset to 1; addr_ok and data_ok SHALL be 0 during reset.
REQ-029 Reset mid-transaction SHALL abandon all outstanding transactions; stale R/B arriving later SHALL produce no data_ok (per REQ-023/024).

Verification
REQ-030 Single read: ch1 req, addr 0x1c000000, ar_ready=1, r(id=1, data 0xDEADBEEF) next cycle -> addr_ok[1] at c0, ar_id=1 at c1, data_ok[1]=1 and rdata[1]=0xDEADBEEF at c2.
REQ-031 Priority: ch0 and ch1 both read in the same cycle -> addr_ok=2'b01; ch1 accepted the cycle after ar handshake of ch0.
REQ-032 Out-of-order: ch0 and ch1 reads outstanding, R returns id 1 then id 0 -> data_ok[1] then data_ok[0], with correct data per channel.
REQ-033 Write then read: ch0 write wstrb 4'b0011, aw_ready delayed 3 cycles, w_ready=1 -> w_valid drops at c2, aw_valid held to c4, ch1 read addr_ok=0 until b_valid cycle, then accepted.
REQ-034 Reset asserted with a read outstanding, then r_valid with that id after release -> no data_ok; new request accepted normally.
